// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode controller: state encoding,
// opcode values, ALU function codes and the conditional-jump test.
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_FETCH2  = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JC    = 4'h8;
  localparam logic [3:0] OP_JNC   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JNZ   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU function codes; the ALU on the data path decodes these same values.
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  // True when a jump opcode's condition is met by the latched flags.
  function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c;
      OP_JNC:  taken = ~c;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = ~z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_decode_op_decode.sv
// Combinational opcode decoder: maps the instruction's upper nibble to the
// ALU function, bus-driver enables and instruction-class flags.
module op_decode
  import fetch_decode_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic [2:0] o_f,
  output logic       o_enDb,
  output logic       o_enR,
  output logic       o_enFf,
  output logic       o_updFlags,
  output logic       o_isJump,
  output logic       o_isHalt
);

  // Decode table; anything not listed behaves as a NOP.
  always_comb begin
    o_f        = ALU_PASS_A;
    o_enDb     = 1'b0;
    o_enR      = 1'b0;
    o_enFf     = 1'b0;
    o_updFlags = 1'b0;
    o_isJump   = 1'b0;
    o_isHalt   = 1'b0;
    case (i_opcode)
      OP_LIT: begin
        o_f = ALU_PASS_B; o_enDb = 1'b1; o_enFf = 1'b1; o_updFlags = 1'b1;
      end
      OP_ADDI: begin
        o_f = ALU_ADD; o_enDb = 1'b1; o_enFf = 1'b1; o_updFlags = 1'b1;
      end
      OP_SUBI: begin
        o_f = ALU_SUB; o_enDb = 1'b1; o_enFf = 1'b1; o_updFlags = 1'b1;
      end
      OP_NANDI: begin
        o_f = ALU_NAND; o_enDb = 1'b1; o_enFf = 1'b1; o_updFlags = 1'b1;
      end
      OP_CMPI: begin
        o_f = ALU_SUB; o_enDb = 1'b1; o_updFlags = 1'b1;
      end
      OP_OUT: begin
        o_f = ALU_PASS_A; o_enR = 1'b1;
      end
      OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
        o_isJump = 1'b1;
      end
      OP_HALT: begin
        o_isHalt = 1'b1;
      end
      default: begin
        o_f = ALU_PASS_A;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch/decode controller for an 8-bit accumulator machine.
// Holds PC, IR, the carry/zero flags and the instruction-sequencing FSM.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [11:0] RST_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic [7:0]  rom_data,
  input  logic        alu_c,
  input  logic        alu_ze,
  output logic [11:0] rom_addr,
  output logic [2:0]  F,
  output logic [4:0]  oprnd,
  output logic        enableDB,
  output logic        enableR,
  output logic        enableFF,
  output logic        c_flag,
  output logic        z_flag,
  output logic        halted
);

  state_t      r_state;
  state_t      w_nextState;
  logic [11:0] r_pc;
  logic [7:0]  r_ir;
  logic        r_c;
  logic        r_z;

  logic [2:0]  w_f;
  logic        w_enDb;
  logic        w_enR;
  logic        w_enFf;
  logic        w_updFlags;
  logic        w_isJump;
  logic        w_isHalt;
  logic        w_inExec;
  logic        w_taken;

  op_decode u_opDecode (
    .i_opcode   (r_ir[7:4]),
    .o_f        (w_f),
    .o_enDb     (w_enDb),
    .o_enR      (w_enR),
    .o_enFf     (w_enFf),
    .o_updFlags (w_updFlags),
    .o_isJump   (w_isJump),
    .o_isHalt   (w_isHalt)
  );

  assign w_inExec = (r_state == ST_EXECUTE);
  assign w_taken  = jump_taken(r_ir[7:4], r_c, r_z);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_FETCH;
    else        r_state <= w_nextState;
  end

  // Next-state logic: every instruction takes three cycles unless stalled in FETCH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FETCH:   w_nextState = hold ? ST_FETCH : ST_DECODE;
      ST_DECODE: begin
        if (w_isJump)      w_nextState = ST_FETCH2;
        else if (w_isHalt) w_nextState = ST_HALT;
        else               w_nextState = ST_EXECUTE;
      end
      ST_EXECUTE: w_nextState = ST_FETCH;
      ST_FETCH2:  w_nextState = ST_FETCH;
      ST_HALT:    w_nextState = ST_HALT;
      default:    w_nextState = ST_FETCH;
    endcase
  end

  // PC and IR: load opcode in FETCH, consume the target byte in FETCH2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RST_PC;
      r_ir <= 8'h00;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (!hold) begin
            r_ir <= rom_data;
            r_pc <= r_pc + 12'd1;
          end
        end
        ST_FETCH2: begin
          if (w_taken) r_pc <= {r_ir[3:0], rom_data};
          else         r_pc <= r_pc + 12'd1;
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  // Flags capture the ALU result only for the arithmetic/logic/compare group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
    end else if (w_inExec && w_updFlags) begin
      r_c <= alu_c;
      r_z <= alu_ze;
    end
  end

  assign rom_addr = r_pc;
  assign oprnd    = {1'b0, r_ir[3:0]};
  assign F        = w_inExec ? w_f : 3'b000;
  assign enableDB = w_inExec & w_enDb;
  assign enableR  = w_inExec & w_enR;
  assign enableFF = w_inExec & w_enFf;
  assign c_flag   = r_c;
  assign z_flag   = r_z;
  assign halted   = (r_state == ST_HALT);

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter SHALL be: RST_PC, 12'h000, PC value loaded on reset.
REQ-002 Ports SHALL be:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
hold  in  1  stall request, sampled in FETCH.
rom_data  in  8  instruction byte, combinational ROM read of rom_addr.
alu_c  in  1  ALU carry output.
alu_ze  in  1  ALU zero output.
rom_addr  out  12  program counter.
F  out  3  ALU function code.
oprnd  out  5  immediate {1'b0, IR[3:0]} to the data-bus driver.
enableDB  out  1  data-bus driver enable.
enableR  out  1  result-bus driver enable.
enableFF  out  1  accumulator load enable.
c_flag  out  1  latched carry.
z_flag  out  1  latched zero.
halted  out  1  high in HALT.

Function
REQ-003 FSM states SHALL be FETCH, DECODE, EXECUTE, FETCH2, HALT.
REQ-004 FETCH: if hold=1, stay in FETCH with PC and IR unchanged; else IR<=rom_data, PC<=PC+1, go to DECODE.
REQ-005 PC SHALL wrap from 12'hFFF to 12'h000.
REQ-006 DECODE SHALL go to FETCH2 for opcodes 0x7-0xB, HALT for 0xF, and EXECUTE otherwise.
REQ-007 Opcodes IR[7:4] in EXECUTE SHALL be (F; enables):
- 0x1 LIT: 010; DB, FF
- 0x2 ADDI: 011; DB, FF
- 0x3 SUBI: 001; DB, FF
- 0x4 NANDI: 100; DB, FF
- 0x5 CMPI: 001; DB only
- 0x6 OUT: 000; R only
- 0x0 and 0xC-0xE: NOP, F=000, no enables
REQ-008 F and all enables SHALL be 0 outside EXECUTE, each enable being a single-cycle pulse.
REQ-009 c_flag<=alu_c and z_flag<=alu_ze SHALL occur on the edge ending EXECUTE for opcodes 0x1-0x5 only; other opcodes leave the flags unchanged.
REQ-010 EXECUTE SHALL always be followed by FETCH.
REQ-011 FETCH2 SHALL read the low target byte at rom_addr and then PC<=PC+1.
REQ-012 Jump conditions: 0x7 JMP always; 0x8 JC c_flag=1; 0x9 JNC c_flag=0; 0xA JZ z_flag=1; 0xB JNZ z_flag=0.
REQ-013 If the condition holds, PC<={IR[3:0], rom_data}, overriding the increment; FETCH2 then goes to FETCH.
REQ-014 FETCH2 SHALL ignore hold.
REQ-015 HALT SHALL hold PC, IR and the flags, assert halted=1, and leave only on reset.
REQ-016 Latency SHALL be 3 cycles per instruction (jumps included) when hold=0.
REQ-017 oprnd SHALL follow IR continuously.

Reset
REQ-018 While reset=0: PC=RST_PC, IR=8'h00, state=FETCH, c_flag=0, z_flag=0, and all enables, F, halted and oprnd are 0; applies asynchronously in any state, including mid-instruction and HALT.
REQ-019 Fetching SHALL begin on the first rising clk edge after reset deasserts.

Structure
REQ-020 A shared package SHALL hold the opcode constants, the state encoding (3-bit) and the ALU F codes, and the ALU module SHALL use the same F codes.
REQ-021 Combinational opcode-to-control decoding SHALL be one sub-module, op_decode; fetch_decode holds PC, IR, flags and the FSM.

Verification
REQ-022 Reset, then ROM {0x15, 0x23, 0x60}: cycle 3 shows F=010, oprnd=5, DB=FF=1; cycle 6 shows F=011, oprnd=3; cycle 9 shows enableR=1 with accumulator 8.
REQ-023 CMPI 5 with accumulator 5 (alu_ze=1), then 0xA0 0x40 (JZ): PC=0x040 after FETCH2; repeat with alu_ze=0: PC=next sequential address.
REQ-024 Hold=1 for 4 cycles during FETCH: PC, IR and outputs are frozen; the instruction completes 4 cycles late with identical outputs.
REQ-025 JMP 0xFFF (0x7F, 0xFF), then a NOP at 0xFFF: next rom_addr is 0x000 (wrap).
REQ-026 Opcode 0xF: halted=1 and PC frozen for 20 cycles; reset pulsed low mid-EXECUTE of a later program: all outputs 0 immediately and PC=RST_PC.
